// File: rtl/match_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_timer_pkg: shared constants for the match timer and its slices |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package match_timer_pkg;

  localparam int SLICE_W = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic bit valid_width(input int w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_timer_if: command/status bundle between a host and match_timer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface match_timer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             match;
  logic             flag;
  logic             running;

  modport master (
    output en, start, stop, oneshot, load, d, clr,
    input  q, match, flag, running
  );

  modport slave (
    input  en, start, stop, oneshot, load, d, clr,
    output q, match, flag, running
  );
endinterface
`default_nettype wire

// File: rtl/match_cmp_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_cmp_slice: 8-bit equality slice with mismatch cascade in/out   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module match_cmp_slice
  import match_timer_pkg::*;
(
  input  wire logic [SLICE_W-1:0] a_i,
  input  wire logic [SLICE_W-1:0] b_i,
  input  wire logic               casc_i,
  output logic                    casc_o
);

  // High means "some slice so far differs"; the chain head is tied low.
  assign casc_o = casc_i | (a_i != b_i);

endmodule
`default_nettype wire

// File: rtl/match_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_timer: up-counter with programmable compare, match pulse, flag |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module match_timer
  import match_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic      clk_i,
  input  wire logic      arst_i,
  match_timer_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE_W;

  if (!valid_width(WIDTH)) begin : g_bad_width
    $error("match_timer: WIDTH must be a non-zero multiple of 8");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             match_q, match_d;
  logic             flag_q, flag_d;
  logic             running_q, running_d;

  logic [NSLICE:0]  casc;
  logic             eq;

  assign casc[0] = 1'b0;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    match_cmp_slice u_slice (
      .a_i   (q_q[i*SLICE_W +: SLICE_W]),
      .b_i   (cmp_q[i*SLICE_W +: SLICE_W]),
      .casc_i(casc[i]),
      .casc_o(casc[i+1])
    );
  end

  assign eq = ~casc[NSLICE];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      q_q       <= '0;
      cmp_q     <= '1;
      match_q   <= 1'b0;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
      flag_q    <= flag_d;
      running_q <= running_d;
    end
  end

  // Next state: STOP outranks START, which outranks counting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.stop)                               state_d = IDLE;
        else if (!bus.start && bus.en && eq && bus.oneshot) state_d = DONE;
      end
      DONE: begin
        if (bus.stop)       state_d = IDLE;
        else if (bus.start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d     = q_q;
    match_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) q_d = '0;
      end
      RUN: begin
        if (bus.stop) begin
          q_d = q_q;
        end else if (bus.start) begin
          q_d = '0;
        end else if (bus.en) begin
          if (eq) begin
            q_d     = '0;
            match_d = 1'b1;
          end else begin
            q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE:    q_d = '0;
      default: q_d = '0;
    endcase
    // A match in the same cycle as CLR leaves the flag set.
    flag_d    = match_d | (flag_q & ~bus.clr);
    running_d = (state_d == RUN);
    cmp_d     = bus.load ? bus.d : cmp_q;
  end

  assign bus.q       = q_q;
  assign bus.match   = match_q;
  assign bus.flag    = flag_q;
  assign bus.running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_match_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_match_timer: directed stimulus with a match-cycle scoreboard      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_match_timer;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  match_timer_if #(.WIDTH(8))  bus8 ();
  match_timer_if #(.WIDTH(16)) bus16 ();

  match_timer #(.WIDTH(8))  dut8  (.clk_i(clk), .arst_i(arst), .bus(bus8));
  match_timer #(.WIDTH(16)) dut16 (.clk_i(clk), .arst_i(arst), .bus(bus16));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp8[$];
  int exp16[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each MATCH pulse must line up with the next expected edge index.
  always @(negedge clk) begin
    if (bus8.match) begin
      checks++;
      if (exp8.size() == 0) begin
        failures++;
        $display("FAIL match8_unexpected actual_cyc=%0d required=none", cyc);
      end else begin
        int e;
        e = exp8.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL match8_cycle actual=%0d required=%0d", cyc, e);
        end
      end
      chk("match8_flag", {31'b0, bus8.flag}, 32'd1);
    end
    if (bus16.match) begin
      checks++;
      if (exp16.size() == 0) begin
        failures++;
        $display("FAIL match16_unexpected actual_cyc=%0d required=none", cyc);
      end else begin
        int e;
        e = exp16.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL match16_cycle actual=%0d required=%0d", cyc, e);
        end
      end
    end
  end

  initial begin
    int s;
    {bus8.en, bus8.start, bus8.stop, bus8.oneshot, bus8.load, bus8.clr} = '0;
    {bus16.en, bus16.start, bus16.stop, bus16.oneshot, bus16.load, bus16.clr} = '0;
    bus8.d  = '0;
    bus16.d = '0;

    #2 arst = 1'b1;
    step(2);
    chk("rst_q",       {24'b0, bus8.q}, 32'd0);
    chk("rst_match",   {31'b0, bus8.match}, 32'd0);
    chk("rst_flag",    {31'b0, bus8.flag}, 32'd0);
    chk("rst_running", {31'b0, bus8.running}, 32'd0);
    arst = 1'b0;
    step(1);

    // Reset compare value is all-ones: first match after 256 enabled cycles.
    bus8.en = 1; bus8.oneshot = 1; bus8.start = 1;
    step(1); s = cyc; bus8.start = 0;
    exp8.push_back(s + 256);
    step(256);
    chk("ff_running_done", {31'b0, bus8.running}, 32'd0);
    chk("ff_q_done",       {24'b0, bus8.q}, 32'd0);

    // Periodic, CMP=5.
    bus8.load = 1; bus8.d = 8'd5; bus8.clr = 1;
    step(1); bus8.load = 0; bus8.clr = 0;
    chk("clr_flag", {31'b0, bus8.flag}, 32'd0);
    bus8.oneshot = 0; bus8.start = 1;
    step(1); s = cyc; bus8.start = 0;
    exp8.push_back(s + 6);
    exp8.push_back(s + 12);
    chk("per_q0",   {24'b0, bus8.q}, 32'd0);
    chk("per_run",  {31'b0, bus8.running}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("per_q", {24'b0, bus8.q}, k % 6);
    end
    chk("per_flag", {31'b0, bus8.flag}, 32'd1);
    bus8.stop = 1; step(1); bus8.stop = 0;

    // One-shot, CMP=3, then rearm.
    bus8.load = 1; bus8.d = 8'd3; bus8.oneshot = 1;
    step(1); bus8.load = 0;
    bus8.start = 1; step(1); s = cyc; bus8.start = 0;
    exp8.push_back(s + 4);
    step(4);
    chk("os_running", {31'b0, bus8.running}, 32'd0);
    chk("os_q",       {24'b0, bus8.q}, 32'd0);
    step(3);
    chk("os_q_hold",  {24'b0, bus8.q}, 32'd0);
    bus8.start = 1; step(1); s = cyc; bus8.start = 0;
    exp8.push_back(s + 4);
    step(4);
    chk("os_rearm_running", {31'b0, bus8.running}, 32'd0);

    // Gapped enable, CMP=10: 11 enabled edges needed.
    bus8.load = 1; bus8.d = 8'd10; step(1); bus8.load = 0;
    bus8.start = 1; step(1); s = cyc; bus8.start = 0;
    exp8.push_back(s + 21);
    for (int i = 0; i < 22; i++) begin
      bus8.en = (i % 2 == 0);
      step(1);
    end
    bus8.en = 1;
    chk("gap_done", {31'b0, bus8.running}, 32'd0);

    // STOP at Q=4.
    bus8.oneshot = 0; bus8.start = 1; step(1); bus8.start = 0;
    step(4);
    chk("stop_pre_q", {24'b0, bus8.q}, 32'd4);
    bus8.stop = 1; step(1); bus8.stop = 0;
    chk("stop_q",       {24'b0, bus8.q}, 32'd4);
    chk("stop_running", {31'b0, bus8.running}, 32'd0);
    step(3);
    chk("stop_q_hold",  {24'b0, bus8.q}, 32'd4);

    // STOP and START on the same edge.
    bus8.start = 1; step(1); bus8.start = 0;
    step(2);
    chk("ss_pre_q", {24'b0, bus8.q}, 32'd2);
    bus8.start = 1; bus8.stop = 1; step(1); bus8.start = 0; bus8.stop = 0;
    chk("ss_running", {31'b0, bus8.running}, 32'd0);
    chk("ss_q",       {24'b0, bus8.q}, 32'd2);

    // CMP=0: back-to-back matches.
    bus8.load = 1; bus8.d = 8'd0; step(1); bus8.load = 0;
    bus8.start = 1; step(1); s = cyc; bus8.start = 0;
    for (int i = 1; i <= 5; i++) exp8.push_back(s + i);
    step(5);
    bus8.stop = 1; step(1); bus8.stop = 0;
    chk("cmp0_match_off", {31'b0, bus8.match}, 32'd0);

    // Load D=2 while Q=7: wrap through 255, then match at 2; CLR collides with the match.
    bus8.load = 1; bus8.d = 8'd100; step(1); bus8.load = 0;
    bus8.start = 1; step(1); s = cyc; bus8.start = 0;
    step(7);
    chk("ld_q7", {24'b0, bus8.q}, 32'd7);
    bus8.load = 1; bus8.d = 8'd2; step(1); bus8.load = 0;
    chk("ld_q8_oldcmp", {24'b0, bus8.q}, 32'd8);
    bus8.clr = 1; step(1); bus8.clr = 0;
    chk("ld_flag_clr", {31'b0, bus8.flag}, 32'd0);
    exp8.push_back(s + 259);
    step(249);
    chk("ld_wrap_q2", {24'b0, bus8.q}, 32'd2);
    bus8.clr = 1; step(1); bus8.clr = 0;
    chk("clr_vs_set_flag", {31'b0, bus8.flag}, 32'd1);
    bus8.stop = 1; step(1); bus8.stop = 0;

    // Asynchronous reset one cycle before a match.
    bus8.load = 1; bus8.d = 8'd50; step(1); bus8.load = 0;
    bus8.start = 1; step(1); bus8.start = 0;
    step(49);
    chk("ar_pre_q", {24'b0, bus8.q}, 32'd49);
    #1 arst = 1'b1;
    #1;
    chk("ar_q",       {24'b0, bus8.q}, 32'd0);
    chk("ar_match",   {31'b0, bus8.match}, 32'd0);
    chk("ar_flag",    {31'b0, bus8.flag}, 32'd0);
    chk("ar_running", {31'b0, bus8.running}, 32'd0);
    step(3);
    arst = 1'b0;
    step(1);
    chk("ar_post_running", {31'b0, bus8.running}, 32'd0);

    // 16-bit: CMP=0x0100 spans two slices; Q=0x0000 equals only the low byte.
    bus16.load = 1; bus16.d = 16'h0100; bus16.oneshot = 1; bus16.en = 1;
    step(1); bus16.load = 0;
    bus16.start = 1; step(1); s = cyc; bus16.start = 0;
    exp16.push_back(s + 257);
    step(1);
    chk("w16_q1", {16'b0, bus16.q}, 32'd1);
    step(255);
    chk("w16_q100", {16'b0, bus16.q}, 32'h100);
    step(1);
    chk("w16_done", {31'b0, bus16.running}, 32'd0);
    step(2);

    chk("sb8_drained",  exp8.size(),  32'd0);
    chk("sb16_drained", exp16.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
